shift_tx_ctrl: RTL and testbench

Sequencing controller for the team's serial shift-register datapath. It accepts a parallel word over a valid/ready handshake, captures it into an internal shift register, and shifts a programmable number of bits out serially, one per clock. It frames each transfer with frame_o and done_o, and enforces a configurable idle gap between frames. It sits between a parallel producer (FSM or FIFO) and any serial consumer or downstream SISO delay line.

---
 rtl/shift_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_shift_tx_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_tx_ctrl.sv
// -----------------------------------------------------------------------------
// shift_tx_ctrl
//
// Parallel-to-serial sequencing controller. A word offered on a valid/ready
// handshake is captured into an internal shift register and shifted out one
// bit per clock. The frame length L is set per word. Each frame is marked by
// frame_o, followed by a one-cycle done_o pulse and an optional idle gap.
//
// Parameters
//   N          word width and maximum frame length in bits (N >= 2)
//   GAP        idle cycles after each frame before the next word is accepted
//   MSB_FIRST  1: send bit L-1 down to bit 0; 0: send bit 0 up to bit L-1
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   data_i    parallel word to serialize
//   len_i     frame length L; 0 or any value > N selects N
//   valid_i   producer offers data_i/len_i
//   ready_o   controller accepts a word this cycle (state is IDLE)
//   serial_o  registered serial data, 0 outside a frame
//   frame_o   high for exactly L cycles while serial_o carries frame bits
//   done_o    one-cycle pulse on the cycle after the last bit
//   busy_o    high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module shift_tx_ctrl #(
    parameter int N         = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           data_i,
    input  logic [$clog2(N):0]     len_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   serial_o,
    output logic                   frame_o,
    output logic                   done_o,
    output logic                   busy_o
);

    localparam int LW = $clog2(N) + 1;
    // Gap counter needs at least one bit even when no gap is configured.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [LW-1:0] N_L      = LW'(N);
    // The GAP state is occupied for GAP cycles; the counter counts down to 0.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state, state_d;
    logic [N-1:0]    sreg, sreg_d;
    logic [LW-1:0]   cnt, cnt_d;
    logic [GW-1:0]   gcnt, gcnt_d;
    logic            serial_d, frame_d, done_d;

    logic [LW-1:0]   len_eff;
    logic [N-1:0]    aligned;

    assign len_eff = ((len_i == '0) || (len_i > N_L)) ? N_L : len_i;

    // For MSB-first output, move bit L-1 up to the top of the register so the
    // shifter always pulls from bit N-1; bits at positions >= L fall off the
    // top and are never sent. LSB-first needs no alignment.
    always_comb begin
        if (MSB_FIRST) begin
            aligned = data_i << (N_L - len_eff);
        end else begin
            aligned = data_i;
        end
    end

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);

    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        cnt_d    = cnt;
        gcnt_d   = gcnt;
        serial_d = 1'b0;
        frame_d  = 1'b0;
        done_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (valid_i) begin
                    // The first bit is registered straight from the input so it
                    // appears the cycle after acceptance.
                    state_d = S_SHIFT;
                    cnt_d   = len_eff;
                    frame_d = 1'b1;
                    if (MSB_FIRST) begin
                        serial_d = aligned[N-1];
                        sreg_d   = aligned << 1;
                    end else begin
                        serial_d = aligned[0];
                        sreg_d   = aligned >> 1;
                    end
                end
            end

            S_SHIFT: begin
                // cnt holds the bits still on the wire, including the current one.
                if (cnt <= LW'(1)) begin
                    done_d  = 1'b1;
                    gcnt_d  = GAP_LOAD;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d   = cnt - LW'(1);
                    frame_d = 1'b1;
                    if (MSB_FIRST) begin
                        serial_d = sreg[N-1];
                        sreg_d   = sreg << 1;
                    end else begin
                        serial_d = sreg[0];
                        sreg_d   = sreg >> 1;
                    end
                end
            end

            S_GAP: begin
                if (gcnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt - GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            sreg     <= '0;
            cnt      <= '0;
            gcnt     <= '0;
            serial_o <= 1'b0;
            frame_o  <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_d;
            sreg     <= sreg_d;
            cnt      <= cnt_d;
            gcnt     <= gcnt_d;
            serial_o <= serial_d;
            frame_o  <= frame_d;
            done_o   <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_tx_ctrl
//
// Directed bench for shift_tx_ctrl. Four instances share one stimulus bus:
//   [0] MSB first, GAP=1   [1] LSB first, GAP=1
//   [2] MSB first, GAP=0   [3] MSB first, GAP=2
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_shift_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [3:0] len;

    logic [3:0] rdy, ser, frm, dn, bsy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    shift_tx_ctrl #(.N(8), .GAP(1), .MSB_FIRST(1'b1)) u_m1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .len_i(len), .valid_i(valid),
        .ready_o(rdy[0]), .serial_o(ser[0]), .frame_o(frm[0]), .done_o(dn[0]), .busy_o(bsy[0]));

    shift_tx_ctrl #(.N(8), .GAP(1), .MSB_FIRST(1'b0)) u_l1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .len_i(len), .valid_i(valid),
        .ready_o(rdy[1]), .serial_o(ser[1]), .frame_o(frm[1]), .done_o(dn[1]), .busy_o(bsy[1]));

    shift_tx_ctrl #(.N(8), .GAP(0), .MSB_FIRST(1'b1)) u_g0 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .len_i(len), .valid_i(valid),
        .ready_o(rdy[2]), .serial_o(ser[2]), .frame_o(frm[2]), .done_o(dn[2]), .busy_o(bsy[2]));

    shift_tx_ctrl #(.N(8), .GAP(2), .MSB_FIRST(1'b1)) u_g2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .len_i(len), .valid_i(valid),
        .ready_o(rdy[3]), .serial_o(ser[3]), .frame_o(frm[3]), .done_o(dn[3]), .busy_o(bsy[3]));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        len   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one word for a single cycle (cycle 0) and returns in cycle 1.
    task automatic send(input logic [7:0] d, input logic [3:0] l);
        data  = d;
        len   = l;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Checks L frame bits on one instance; exp holds the bits in send order
    // with the first bit at position L-1. Returns in the cycle after the frame.
    task automatic chk_bits(input string tag, input int inst, input logic [7:0] exp, input int l);
        for (int i = 0; i < l; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), ser[inst], exp[l-1-i]);
            chk($sformatf("%s_frm%0d", tag, i), frm[inst], 1);
            tick();
        end
    endtask

    // Random-phase scoreboard state
    int         acc_cnt [4];
    int         dn_cnt  [4];
    logic [7:0] sw;
    int         srem;
    int         err;

    function automatic int eff_len(input logic [3:0] l);
        return (l == 0 || l > 8) ? 8 : int'(l);
    endfunction

    task automatic sb_cycle();
        for (int i = 0; i < 4; i++) if (dn[i]) dn_cnt[i]++;
        if (srem > 0) begin
            if (ser[0] !== sw[srem-1] || frm[0] !== 1'b1) err++;
            srem--;
        end else if (frm[0] !== 1'b0 || ser[0] !== 1'b0) begin
            err++;
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         cyc;

        // ---- Reset and idle outputs
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_rdy%0d_c%0d", i, c), rdy[i], 1);
                chk($sformatf("rst_bsy%0d_c%0d", i, c), bsy[i], 0);
                chk($sformatf("rst_ser%0d_c%0d", i, c), ser[i], 0);
                chk($sformatf("rst_frm%0d_c%0d", i, c), frm[i], 0);
                chk($sformatf("rst_dn%0d_c%0d",  i, c), dn[i], 0);
            end
            tick();
        end

        // ---- 0xA5, full length: 1,0,1,0,0,1,0,1 in either order
        send(8'hA5, 4'd0);
        pat = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_m_bit%0d", i), ser[0], pat[7-i]);
            chk($sformatf("a5_l_bit%0d", i), ser[1], pat[7-i]);
            chk($sformatf("a5_frm%0d", i), frm[0], 1);
            chk($sformatf("a5_rdy%0d", i), rdy[0], 0);
            chk($sformatf("a5_bsy%0d", i), bsy[0], 1);
            tick();
        end
        // cycle 9
        chk("a5_c9_done",    dn[0], 1);
        chk("a5_c9_rdy",     rdy[0], 0);
        chk("a5_c9_frm",     frm[0], 0);
        chk("a5_c9_ser",     ser[0], 0);
        chk("a5_c9_g0_done", dn[2], 1);
        chk("a5_c9_g0_rdy",  rdy[2], 1);
        chk("a5_c9_g2_rdy",  rdy[3], 0);
        tick();
        // cycle 10
        chk("a5_c10_rdy",    rdy[0], 1);
        chk("a5_c10_done",   dn[0], 0);
        chk("a5_c10_g2_rdy", rdy[3], 0);
        chk("a5_c10_g2_bsy", bsy[3], 1);
        tick();
        // cycle 11
        chk("a5_c11_g2_rdy", rdy[3], 1);

        // ---- Short frame: 0xF6, L=3
        do_reset();
        send(8'hF6, 4'd3);
        pat = 8'b0000_0110;   // MSB first: 1,1,0
        chk_bits("f6_m", 0, pat, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("f6_m_bit%0d", i), ser[0], pat[2-i]);
            chk($sformatf("f6_l_bit%0d", i), ser[1], (i == 0) ? 0 : 1);
            chk($sformatf("f6_frm_m%0d", i), frm[0], 1);
            chk($sformatf("f6_frm_l%0d", i), frm[1], 1);
            tick();
        end
        chk("f6_end_frm_m", frm[0], 0);
        chk("f6_end_frm_l", frm[1], 0);
        chk("f6_end_ser_m", ser[0], 0);
        chk("f6_end_done_m", dn[0], 1);
        chk("f6_end_done_l", dn[1], 1);

        // ---- Over-range length: len 15 gives 8 bits of 0xC3
        do_reset();
        send(8'hC3, 4'd15);
        chk_bits("c3_m", 0, 8'b1100_0011, 8);
        chk("c3_end_frm",  frm[0], 0);
        chk("c3_end_done", dn[0], 1);

        // ---- Back-to-back, GAP=0: 0x81 then 0x7E accepted on the done cycle
        do_reset();
        data  = 8'h81;
        len   = 4'd8;
        valid = 1'b1;
        tick();
        data = 8'h7E;
        chk_bits("b2b_81", 2, 8'b1000_0001, 8);
        chk("b2b_c9_done", dn[2], 1);
        chk("b2b_c9_rdy",  rdy[2], 1);
        tick();
        valid = 1'b0;
        chk_bits("b2b_7e", 2, 8'b0111_1110, 8);
        chk("b2b_c18_done", dn[2], 1);
        chk("b2b_c18_frm",  frm[2], 0);

        // ---- Back-to-back, GAP=2: second acceptance at cycle 11
        do_reset();
        data  = 8'h81;
        len   = 4'd8;
        valid = 1'b1;
        tick();
        data = 8'h7E;
        repeat (8) tick();
        chk("g2_c9_done", dn[3], 1);
        chk("g2_c9_rdy",  rdy[3], 0);
        tick();
        chk("g2_c10_rdy", rdy[3], 0);
        chk("g2_c10_frm", frm[3], 0);
        tick();
        chk("g2_c11_rdy", rdy[3], 1);
        tick();
        valid = 1'b0;
        chk("g2_c12_frm", frm[3], 1);
        chk("g2_c12_ser", ser[3], 0);
        tick();
        chk("g2_c13_ser", ser[3], 1);

        // ---- Reset during the 4th bit aborts the frame
        do_reset();
        send(8'hA5, 4'd0);
        repeat (3) tick();
        chk("rmid_bit4_frm", frm[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_frm",  frm[0], 0);
        chk("rmid_ser",  ser[0], 0);
        chk("rmid_done", dn[0], 0);
        chk("rmid_rdy",  rdy[0], 1);
        chk("rmid_bsy",  bsy[0], 0);
        tick();
        chk("rmid_done_next", dn[0], 0);
        send(8'h3C, 4'd0);
        chk_bits("rmid_3c", 0, 8'b0011_1100, 8);
        chk("rmid_3c_done", dn[0], 1);

        // ---- Random handshake traffic over 1000 frames
        do_reset();
        srem = 0;
        err  = 0;
        cyc  = 0;
        for (int i = 0; i < 4; i++) begin
            acc_cnt[i] = 0;
            dn_cnt[i]  = 0;
        end
        while (acc_cnt[0] < 1000 && cyc < 40000) begin
            logic [3:0] acc;
            sb_cycle();
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            len   = 4'($urandom_range(0, 15));
            acc   = rdy & {4{valid}};
            for (int i = 0; i < 4; i++) if (acc[i]) acc_cnt[i]++;
            if (acc[0]) begin
                sw   = data;
                srem = eff_len(len);
            end
            tick();
            cyc++;
        end
        valid = 1'b0;
        repeat (20) begin
            sb_cycle();
            tick();
        end
        chk("rand_frames_reached", (acc_cnt[0] >= 1000) ? 1 : 0, 1);
        chk("rand_bit_errors", err, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rand_done_vs_acc%0d", i), dn_cnt[i], acc_cnt[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
